controlador_atributos_param: RTL and testbench

- Parametrised successor of the pet attribute controller. Holds NUM_ATRIB saturating attribute counters (default 3: fome, felicidade, sono) and updates them on a prescaled tick according to the current pet activity.
- Adds per-attribute low alerts, a sticky death flag that freezes the attributes, a synchronous revive, and an invalid-activity error flag.
- Sits between the activity FSM, which drives `estado`, and the display/HUD logic, which consumes `atributos`, `alerta` and `morreu`.

---
 rtl/controlador_atributos_param.sv | 86 ++++++++
 tb/tb_controlador_atributos_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_atributos_param.sv
// rtl/controlador_atributos_param.sv - prescaled saturating pet attribute counters with alerts, death and revive
module controlador_atributos_param #(
  parameter int NUM_ATRIB     = 3,
  parameter int W             = 8,
  parameter int MAX_VALOR     = 100,
  parameter int VEL_SUBIDA    = 7,
  parameter int VEL_DESCIDA   = 1,
  parameter int DIVISOR       = 256,
  parameter int LIMIAR_ALERTA = 25,
  parameter int LIMIAR_MORTE  = 10,
  parameter logic [NUM_ATRIB*W-1:0] INICIAIS = 24'h324650
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ATRIB-1:0]   estado,
  input  logic                   reiniciar,
  output logic [NUM_ATRIB*W-1:0] atributos,
  output logic [NUM_ATRIB-1:0]   alerta,
  output logic                   tick,
  output logic                   erro,
  output logic                   morreu
);

  localparam int PW = $clog2(DIVISOR);
  localparam logic [PW-1:0] PRESC_FIM = PW'(DIVISOR - 1);

  // Arithmetic constants sized to W+1 bits so rise/fall never wrap.
  localparam logic [W:0] MAX_W1    = (W+1)'(MAX_VALOR);
  localparam logic [W:0] SUB_W1    = (W+1)'(VEL_SUBIDA);
  localparam logic [W:0] LIM_SUB   = (W+1)'(MAX_VALOR - VEL_SUBIDA);
  localparam logic [W:0] DESC_W1   = (W+1)'(VEL_DESCIDA);
  localparam logic [W:0] ALERTA_W1 = (W+1)'(LIMIAR_ALERTA);
  localparam logic [W:0] MORTE_W1  = (W+1)'(LIMIAR_MORTE);

  logic [PW-1:0]          presc;
  logic                   fim;
  logic                   multiplo;
  logic [NUM_ATRIB*W-1:0] prox_pack;
  logic [NUM_ATRIB-1:0]   critico;

  assign fim      = (presc == PRESC_FIM);
  // More than one activity bit: x & (x-1) clears only the lowest set bit.
  assign multiplo = |(estado & (estado - 1'b1));

  for (genvar i = 0; i < NUM_ATRIB; i++) begin : g_atrib
    logic [W:0] atual;
    logic [W:0] sobe;
    logic [W:0] desce;
    logic [W:0] prox;

    assign atual = {1'b0, atributos[i*W +: W]};
    assign sobe  = (atual > LIM_SUB) ? MAX_W1 : atual + SUB_W1;
    assign desce = (atual < DESC_W1) ? '0 : atual - DESC_W1;
    assign prox  = (estado[i] && !multiplo) ? sobe : desce;

    assign prox_pack[i*W +: W] = prox[W-1:0];
    assign critico[i]          = (prox <= MORTE_W1);
    assign alerta[i]           = (atual <= ALERTA_W1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      atributos <= INICIAIS;
      tick      <= 1'b0;
      erro      <= 1'b0;
      morreu    <= 1'b0;
    end else if (reiniciar) begin
      presc     <= '0;
      atributos <= INICIAIS;
      tick      <= 1'b0;
      erro      <= 1'b0;
      morreu    <= 1'b0;
    end else begin
      presc <= fim ? '0 : presc + 1'b1;
      tick  <= fim;
      // A dead pet keeps its last attributes and error until revived.
      if (fim && !morreu) begin
        atributos <= prox_pack;
        erro      <= multiplo;
        morreu    <= |critico;
      end
    end
  end

endmodule

// File: tb/tb_controlador_atributos_param.sv
// tb/tb_controlador_atributos_param.sv - model-checked directed bench for controlador_atributos_param
module tb_controlador_atributos_param;

  localparam int DIV = 4;
  localparam logic [23:0] INI_A = 24'h324650;
  localparam logic [23:0] INI_B = 24'h0B460B;
  localparam logic [23:0] INI_C = 24'h324602;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  estado [3];
  logic        reiniciar [3];
  logic [23:0] atributos [3];
  logic [2:0]  alerta [3];
  logic        tick [3];
  logic        erro [3];
  logic        morreu [3];

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  controlador_atributos_param #(.DIVISOR(DIV), .INICIAIS(INI_A)) u_a (
    .clk(clk), .reset(reset), .estado(estado[0]), .reiniciar(reiniciar[0]),
    .atributos(atributos[0]), .alerta(alerta[0]), .tick(tick[0]), .erro(erro[0]), .morreu(morreu[0]));

  controlador_atributos_param #(.DIVISOR(DIV), .INICIAIS(INI_B)) u_b (
    .clk(clk), .reset(reset), .estado(estado[1]), .reiniciar(reiniciar[1]),
    .atributos(atributos[1]), .alerta(alerta[1]), .tick(tick[1]), .erro(erro[1]), .morreu(morreu[1]));

  controlador_atributos_param #(.DIVISOR(DIV), .VEL_DESCIDA(3), .INICIAIS(INI_C)) u_c (
    .clk(clk), .reset(reset), .estado(estado[2]), .reiniciar(reiniciar[2]),
    .atributos(atributos[2]), .alerta(alerta[2]), .tick(tick[2]), .erro(erro[2]), .morreu(morreu[2]));

  // Behavioural model: cycle count since reset/revive, integer attribute values.
  int m_attr [3][3];
  int m_cnt [3];
  bit m_dead [3];
  bit m_erro [3];
  bit m_tick [3];

  function automatic int ini_of(int k, int i);
    logic [23:0] p;
    p = (k == 0) ? INI_A : (k == 1) ? INI_B : INI_C;
    return int'(p[i*8 +: 8]);
  endfunction

  function automatic int desc_of(int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic void model_init(int k);
    for (int i = 0; i < 3; i++) m_attr[k][i] = ini_of(k, i);
    m_cnt[k]  = 0;
    m_dead[k] = 0;
    m_erro[k] = 0;
    m_tick[k] = 0;
  endfunction

  function automatic void model_step(int k);
    int ones;
    m_cnt[k]  = m_cnt[k] + 1;
    m_tick[k] = (m_cnt[k] % DIV == 0);
    if (m_tick[k] && !m_dead[k]) begin
      ones = $countones(estado[k]);
      for (int i = 0; i < 3; i++) begin
        if (ones == 1 && estado[k][i]) m_attr[k][i] = (m_attr[k][i] + 7 > 100) ? 100 : m_attr[k][i] + 7;
        else m_attr[k][i] = (m_attr[k][i] - desc_of(k) < 0) ? 0 : m_attr[k][i] - desc_of(k);
      end
      m_erro[k] = (ones > 1);
      for (int i = 0; i < 3; i++) if (m_attr[k][i] <= 10) m_dead[k] = 1;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) model_init(k);
      else if (reiniciar[k]) model_init(k);
      else model_step(k);
    end
  end

  function automatic logic [23:0] exp_pack(int k);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'(m_attr[k][i]);
    return r;
  endfunction

  function automatic logic [2:0] exp_alert(int k);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (m_attr[k][i] <= 25);
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model inst%0d atributos", k), atributos[k], exp_pack(k));
        check($sformatf("model inst%0d alerta", k), alerta[k], exp_alert(k));
        check($sformatf("model inst%0d tick", k), tick[k], m_tick[k]);
        check($sformatf("model inst%0d erro", k), erro[k], m_erro[k]);
        check($sformatf("model inst%0d morreu", k), morreu[k], m_dead[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      estado[k]    = 3'b000;
      reiniciar[k] = 1'b0;
    end
    estado[1] = 3'b100;
    cyc(2);
    armed = 1;
    check("reset atributos", atributos[0], 24'h324650);
    check("reset tick", tick[0], 0);
    check("reset morreu", morreu[0], 0);
    check("reset alerta default", alerta[0], 3'b000);
    check("reset alerta B", alerta[1], 3'b101);
    reset = 1'b0;

    cyc(3);
    check("no early tick", tick[0], 0);
    cyc(1);
    check("tick1", tick[0], 1);
    check("tick1 idle atributos", atributos[0], 24'h31454F);
    check("tick1 erro", erro[0], 0);
    check("tick1 alerta", alerta[0], 3'b000);
    check("B death atributos", atributos[1], 24'h12450A);
    check("B morreu", morreu[1], 1);
    check("B alerta", alerta[1], 3'b101);
    check("C fall clamps to 0", atributos[2], 24'h2F4300);

    estado[0] = 3'b100;
    cyc(4);
    check("tick2", tick[0], 1);
    check("B frozen", atributos[1], 24'h12450A);
    check("B tick keeps running", tick[1], 1);
    repeat (7) cyc(4);
    check("sono saturates", atributos[0], 24'h643D47);
    cyc(4);
    check("sono holds at max", atributos[0], 24'h643C46);

    estado[0] = 3'b011;
    cyc(4);
    check("multi-bit all fall", atributos[0], 24'h633B45);
    check("multi-bit erro", erro[0], 1);
    estado[0] = 3'b001;
    cyc(4);
    check("fome rises", atributos[0], 24'h623A4C);
    check("erro cleared", erro[0], 0);

    cyc(3);
    reiniciar[1] = 1'b1;
    cyc(1);
    reiniciar[1] = 1'b0;
    check("revive atributos", atributos[1], 24'h0B460B);
    check("revive morreu", morreu[1], 0);
    check("revive beats tick", tick[1], 0);
    cyc(3);
    check("revive no early tick", tick[1], 0);
    cyc(1);
    check("revive next tick", tick[1], 1);
    check("revive dies again", morreu[1], 1);

    #1 reset = 1'b1;
    #1;
    check("async reset atributos", atributos[0], 24'h324650);
    check("async reset tick", tick[0], 0);
    check("async reset morreu", morreu[2], 0);
    check("async reset alerta B", alerta[1], 3'b101);
    estado[0] = 3'b000;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    check("post-reset tick", tick[0], 1);
    check("post-reset atributos", atributos[0], 24'h31454F);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
